int_ctrl_nest: RTL

- Parametrised next-generation interrupt controller for the MIPS CPU.
- Provides N_CH edge-triggered request channels, each with an input synchroniser, a pending latch, a mask and a software clear.
- Adds an in-service register so a higher-priority interrupt can nest over a lower one, with ack/eret handshakes to the CPU's exception logic.
- Sits between the board button/peripheral request lines and the CPU's CP0/exception unit.

---
 rtl/int_pkg.sv | 17 +
 rtl/int_chan.sv | 44 ++++
 rtl/int_ctrl_nest.sv | 82 ++++++++
 3 files changed

// File: rtl/int_pkg.sv
// Shared constants and helpers for the nesting interrupt controller.
package int_pkg;

    localparam int N_CH_DEF = 8;
    localparam int SYNC_DEF = 2;

    // Returns the highest set bit index of vec, or -1 when vec is zero.
    function automatic logic signed [6:0] msb_index(input logic [31:0] vec);
        logic signed [6:0] idx;
        idx = -7'sd1;
        for (int i = 0; i < 32; i++) begin
            if (vec[i]) idx = 7'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/int_chan.sv
// One request channel: input synchroniser, rising-edge detect and pending latch.
module int_chan #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic req_i,
    input  logic clr_i,
    input  logic ack_hit_i,
    output logic pending_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   pend_q;
    logic                   pend_d;
    logic                   rise;

    // History resets to 0, so a request held through reset release counts as an edge.
    assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

    always_comb begin
        pend_d = pend_q;
        if (rise)
            pend_d = 1'b1;
        else if (clr_i || ack_hit_i)
            pend_d = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], req_i};
            prev_q <= sync_q[SYNC_STAGES-1];
            pend_q <= pend_d;
        end
    end

    assign pending_o = pend_q;

endmodule

// File: rtl/int_ctrl_nest.sv
// Nesting interrupt controller: per-channel pending, in-service stack and
// priority ceiling with ack/eret handshakes to the CPU exception logic.
module int_ctrl_nest
    import int_pkg::*;
#(
    parameter int N_CH        = N_CH_DEF,
    parameter int SYNC_STAGES = SYNC_DEF,
    parameter int NO_W        = $clog2(N_CH + 1)
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic [N_CH-1:0] int_req_i,
    input  logic [N_CH-1:0] int_mask_i,
    input  logic [N_CH-1:0] int_clr_i,
    input  logic            ie_i,
    input  logic            int_ack_i,
    input  logic            int_eret_i,
    output logic            int_o,
    output logic [NO_W-1:0] int_no_o,
    output logic [N_CH-1:0] pending_o,
    output logic [N_CH-1:0] in_service_o
);

    logic [N_CH-1:0]   pending;
    logic [N_CH-1:0]   eligible;
    logic [N_CH-1:0]   ack_hit;
    logic [N_CH-1:0]   in_service_q;
    logic [N_CH-1:0]   in_service_d;
    logic signed [6:0] ceil_idx;
    logic signed [6:0] win_idx;
    logic              ack_acc;

    for (genvar g = 0; g < N_CH; g++) begin : g_chan
        int_chan #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_chan (
            .clk_i     (clk_i),
            .rst_n_i   (rst_n_i),
            .req_i     (int_req_i[g]),
            .clr_i     (int_clr_i[g]),
            .ack_hit_i (ack_hit[g]),
            .pending_o (pending[g])
        );
    end

    always_comb begin
        ceil_idx = msb_index(32'(in_service_q));
        eligible = '0;
        for (int i = 0; i < N_CH; i++) begin
            eligible[i] = pending[i] & ~int_mask_i[i] & (i > int'(ceil_idx));
        end
        win_idx = msb_index(32'(eligible));
    end

    // int_no ignores ie so software can poll the winner with interrupts off.
    assign int_no_o = NO_W'(win_idx + 7'sd1);
    assign int_o    = ie_i & (|eligible);
    assign ack_acc  = int_ack_i & int_o;

    always_comb begin
        ack_hit      = '0;
        in_service_d = in_service_q;
        for (int i = 0; i < N_CH; i++) begin
            if (int_eret_i && (i == int'(ceil_idx))) in_service_d[i] = 1'b0;
        end
        for (int i = 0; i < N_CH; i++) begin
            if (ack_acc && (i == int'(win_idx))) begin
                ack_hit[i]      = 1'b1;
                in_service_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) in_service_q <= '0;
        else          in_service_q <= in_service_d;
    end

    assign pending_o    = pending;
    assign in_service_o = in_service_q;

endmodule
